// File: rtl/pcm_sample_feeder.sv
// pcm_sample_feeder
//   Buffers stereo PCM pairs from a valid/ready producer in a small FIFO and
//   releases one pair per output sample period. The period is paced by a
//   fractional phase accumulator on clk, so the long-run rate is exactly
//   SAMPLE_HZ/CLK_HZ with no drift. The released pair is held on
//   o_left_pcm/o_right_pcm for the delta-sigma modulator. When a sample
//   period arrives with the FIFO empty, the last pair is held and the event
//   is flagged and counted.
//
// Ports
//   clk              system clock
//   aclr             asynchronous active-high reset
//   i_in_valid       producer presents a sample pair
//   o_in_ready       FIFO can accept (not full, from the registered level)
//   i_in_left        left sample (unsigned)
//   i_in_right       right sample (unsigned)
//   o_left_pcm       held left sample to the DSM
//   o_right_pcm      held right sample to the DSM
//   o_sample_tick    one-cycle pulse per sample period
//   o_underrun       one-cycle pulse: a tick found the FIFO empty
//   o_underrun_count saturating count of underruns
//   o_fifo_level     FIFO occupancy, 0..2^FIFO_AW
module pcm_sample_feeder #(
  parameter int AUDIO_BITS = 12,
  parameter int CLK_HZ     = 50000000,
  parameter int SAMPLE_HZ  = 44100,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [AUDIO_BITS-1:0] i_in_left,
  input  logic [AUDIO_BITS-1:0] i_in_right,
  output logic [AUDIO_BITS-1:0] o_left_pcm,
  output logic [AUDIO_BITS-1:0] o_right_pcm,
  output logic                  o_sample_tick,
  output logic                  o_underrun,
  output logic [15:0]           o_underrun_count,
  output logic [FIFO_AW:0]      o_fifo_level
);

  localparam int               DEPTH  = 1 << FIFO_AW;
  localparam logic [31:0]      C_STEP = 32'(SAMPLE_HZ);
  localparam logic [31:0]      C_MOD  = 32'(CLK_HZ);
  localparam logic [FIFO_AW:0] C_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] C_ONE  = (FIFO_AW+1)'(1);

  // ---------------------------------------------------------------------
  // Phase accumulator: adds SAMPLE_HZ every clock and wraps modulo CLK_HZ.
  // Each wrap is one sample period; the remainder carries over so the
  // average rate is exact.
  // ---------------------------------------------------------------------
  logic [31:0] r_acc;
  logic        r_tick;
  logic [31:0] w_sum;
  logic        w_wrap;

  always_comb begin
    w_sum  = r_acc + C_STEP;
    w_wrap = (w_sum >= C_MOD);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_wrap ? (w_sum - C_MOD) : w_sum;
      r_tick <= w_wrap;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO. Pointers are FIFO_AW bits and wrap naturally; the separate level
  // register tells full from empty. Storage is not reset: clearing the
  // pointers and level is enough to discard the contents.
  // ---------------------------------------------------------------------
  logic [2*AUDIO_BITS-1:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0]      r_wr_ptr;
  logic [FIFO_AW-1:0]      r_rd_ptr;
  logic [FIFO_AW:0]        r_level;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic [AUDIO_BITS-1:0]   w_head_left;
  logic [AUDIO_BITS-1:0]   w_head_right;

  always_comb begin
    w_empty = (r_level == '0);
    w_full  = (r_level == C_FULL);
    // Ready comes from the registered level only, so a pop on a full FIFO
    // frees the slot for the following cycle, not the current one.
    w_push  = i_in_valid && !w_full;
    // A tick on an empty FIFO does not pass a same-cycle push through.
    w_pop   = r_tick && !w_empty;
    {w_head_left, w_head_right} = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_in_left, i_in_right};
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + C_ONE;
        2'b01:   r_level <= r_level - C_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output holding registers and underrun bookkeeping. Everything here
  // updates on the edge that ends the tick cycle, so the DSM sees one
  // change per sample period at most.
  // ---------------------------------------------------------------------
  logic [AUDIO_BITS-1:0] r_left_pcm;
  logic [AUDIO_BITS-1:0] r_right_pcm;
  logic                  r_underrun;
  logic [15:0]           r_underrun_count;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_left_pcm       <= '0;
      r_right_pcm      <= '0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      if (w_pop) begin
        r_left_pcm  <= w_head_left;
        r_right_pcm <= w_head_right;
      end
      r_underrun <= r_tick && w_empty;
      if (r_tick && w_empty && (r_underrun_count != 16'hFFFF)) begin
        r_underrun_count <= r_underrun_count + 16'd1;
      end
    end
  end

  assign o_in_ready       = !w_full;
  assign o_left_pcm       = r_left_pcm;
  assign o_right_pcm      = r_right_pcm;
  assign o_sample_tick    = r_tick;
  assign o_underrun       = r_underrun;
  assign o_underrun_count = r_underrun_count;
  assign o_fifo_level     = r_level;

endmodule

// File: doc/pcm_sample_feeder.md
# pcm_sample_feeder

Upstream stage of the 44.1 kHz audio path: accepts stereo PCM samples from any producer over a valid/ready handshake and buffers them in a small FIFO. It releases one sample pair per 44.1 kHz sample period, paced by a fractional phase accumulator on the system clock. It drives the held `left_pcm`/`right_pcm` words consumed by the stereo delta-sigma modulator. On underrun it holds the last sample and counts the event.

## Interface
- `AUDIO_BITS`, 12, PCM word width per channel (unsigned, matches DSM input).
- `CLK_HZ`, 50000000, clk frequency in Hz.
- `SAMPLE_HZ`, 44100, output sample rate in Hz; must satisfy 0 < SAMPLE_HZ < CLK_HZ.
- `FIFO_AW`, 4, FIFO address width; depth = 2^FIFO_AW pairs.
- `clk`  in  1  system clock.
- `aclr`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  producer has a sample pair.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_left`  in  AUDIO_BITS  left sample.
- `in_right`  in  AUDIO_BITS  right sample.
- `left_pcm`  out  AUDIO_BITS  held left sample to DSM.
- `right_pcm`  out  AUDIO_BITS  held right sample to DSM.
- `sample_tick`  out  1  one-cycle pulse per sample period.
- `underrun`  out  1  one-cycle pulse: tick occurred with FIFO empty.
- `underrun_count`  out  16  saturating underrun counter.
- `fifo_level`  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW.

## Operation
- Reset (async, while `aclr`=1): accumulator=0, FIFO empty, `fifo_level`=0, `left_pcm`=`right_pcm`=0, `sample_tick`=0, `underrun`=0, `underrun_count`=0. `in_ready`=1, driven combinationally from the registered level.
- Phase accumulator: 32-bit register `acc`. Each clk: s = acc + SAMPLE_HZ. If s >= CLK_HZ, then acc <= s - CLK_HZ and the tick register is set to 1. Otherwise acc <= s and the tick register is set to 0. `sample_tick` is this register.
- Long-run tick rate is exactly SAMPLE_HZ/CLK_HZ, with no cumulative drift.
- Push: when `in_valid` && `in_ready`, {in_left,in_right} is written at the tail and the level is incremented.
- Pop: on any cycle where `sample_tick`=1:
  - FIFO non-empty: the head is loaded into `left_pcm`/`right_pcm` and the level is decremented.
  - FIFO empty: outputs hold their previous value, `underrun` pulses for 1 cycle, and `underrun_count` increments, saturating at 0xFFFF.
- Simultaneous push and pop: level is unchanged; both take effect.
- Push into an empty FIFO on a tick cycle: no pass-through. The pair enters the FIFO, and the underrun is still flagged.
- Full FIFO: `in_ready`=0 and no write occurs. A pop in the same cycle does not raise `in_ready` until the next cycle.
- Pointers wrap modulo 2^FIFO_AW. Level distinguishes full from empty.
- Reset mid-operation: FIFO contents are discarded and all state returns to its reset values immediately.

## Timing
- After `aclr` falls, the first `sample_tick` occurs in the cycle k = ceil(CLK_HZ/SAMPLE_HZ). With the defaults, k = 1134. For each subsequent tick, the gap is floor or ceil of CLK_HZ/SAMPLE_HZ (1133 or 1134).
- `sample_tick` is high for exactly 1 cycle and is never high in consecutive cycles.
- Pop latency: `left_pcm`/`right_pcm` change on the clk edge ending the tick cycle. The new value is visible on the cycle after `sample_tick`.
- Push-to-level latency: 1 cycle. `in_ready` reflects the registered level.
- `underrun` coincides with the cycle after the tick, aligned with the (unchanged) pcm update slot. `underrun_count` updates on the same edge.
- The outputs change at most once per tick, so the DSM sees a held word for a full sample period.

## Test plan
- Rate check, CLK_HZ=100, SAMPLE_HZ=7: ticks in cycles 15, 29, 43, 58, 72, 86, 100 after reset release -> exactly 7 ticks per 100 cycles, repeating identically for the next 100.
- Ordered playback: push pairs (0x001,0xFFF), (0x002,0xFFE), (0x003,0xFFD) before the first tick -> `left_pcm`/`right_pcm` step through them on successive ticks, and `fifo_level` goes 3, 2, 1, 0.
- Underrun: empty FIFO, last output 0x123/0x456, 3 ticks -> outputs hold 0x123/0x456, 3 `underrun` pulses, and `underrun_count`=3. Preloading `underrun_count` to 0xFFFE, then 3 more ticks -> count saturates at 0xFFFF.
- Full/backpressure, FIFO_AW=2: hold `in_valid`=1 -> 4 accepts, then `in_ready`=0 with `fifo_level`=4. A tick pops one pair, after which `in_ready`=1 on the next cycle and exactly one more accept occurs.
- Simultaneous push+pop at level 2 on a tick cycle -> level stays 2 and the popped pair is the oldest. Push into an empty FIFO on a tick cycle -> underrun flagged and level becomes 1.
- Async reset mid-stream: assert `aclr` between clk edges with level 3 -> all outputs are 0 immediately and `in_ready`=1. After release, the first tick occurs again at cycle k.
